// File: rtl/spi_master.sv
// SPI mode-0 initiator (CPOL=0, CPHA=0), MSB first, with one-hot active-low chip-selects.
// keep_cs holds the selected slave across words; a different held target gets one idle phase first.
module spi_master #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4,
   parameter int NUM_CS  = 3,
   localparam int SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [SEL_W-1:0]  cs_sel,
   input  logic              keep_cs,
   input  logic              cs_release,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {
      IDLE,
      GAP,
      SETUP,
      HIGH,
      LOW,
      HOLD
   } state_t;

   state_t              state;
   logic [DIV_W-1:0]    div_cnt;
   logic [BIT_W-1:0]    bit_cnt;
   logic [DATA_W-1:0]   tx_shift;
   logic [DATA_W-1:0]   rx_shift;
   logic [SEL_W-1:0]    cur_sel;
   logic                cur_keep;
   logic                held;
   logic                phase_end;

   // An out-of-range index decodes to all-high, so the transfer runs with no slave selected.
   function automatic logic [NUM_CS-1:0] cs_decode(input logic [SEL_W-1:0] sel);
      logic [NUM_CS-1:0] m;
      m = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (int'(sel) == i) m[i] = 1'b0;
      end
      return m;
   endfunction

   assign phase_end = (div_cnt == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         cur_sel  <= '0;
         cur_keep <= 1'b0;
         held     <= 1'b0;
         ready    <= 1'b1;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cs_n     <= '1;
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         rx_valid <= 1'b0;
         div_cnt  <= phase_end ? '0 : div_cnt + DIV_W'(1);

         case (state)
            IDLE: begin
               div_cnt <= '0;
               if (cs_release) begin
                  cs_n <= '1;
                  held <= 1'b0;
               end else if (start) begin
                  tx_shift <= tx_data;
                  cur_sel  <= cs_sel;
                  cur_keep <= keep_cs;
                  bit_cnt  <= '0;
                  held     <= 1'b0;
                  ready    <= 1'b0;
                  // Switching away from a held slave: drop it now, select the new one a phase later.
                  if (held && (cs_sel != cur_sel)) begin
                     cs_n  <= '1;
                     state <= GAP;
                  end else begin
                     cs_n  <= cs_decode(cs_sel);
                     mosi  <= tx_data[DATA_W-1];
                     state <= SETUP;
                  end
               end
            end

            GAP: begin
               if (phase_end) begin
                  cs_n  <= cs_decode(cur_sel);
                  mosi  <= tx_shift[DATA_W-1];
                  state <= SETUP;
               end
            end

            SETUP, LOW: begin
               if (phase_end) begin
                  sclk     <= 1'b1;
                  rx_shift <= {rx_shift[DATA_W-2:0], miso};
                  state    <= HIGH;
               end
            end

            HIGH: begin
               if (phase_end) begin
                  sclk <= 1'b0;
                  if (bit_cnt != BIT_W'(DATA_W - 1)) begin
                     mosi     <= tx_shift[DATA_W-2];
                     tx_shift <= tx_shift << 1;
                     bit_cnt  <= bit_cnt + BIT_W'(1);
                     state    <= LOW;
                  end else begin
                     state <= HOLD;
                  end
               end
            end

            HOLD: begin
               if (phase_end) begin
                  rx_data  <= rx_shift;
                  rx_valid <= 1'b1;
                  ready    <= 1'b1;
                  held     <= cur_keep;
                  if (!cur_keep) cs_n <= '1;
                  state    <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
               ready <= 1'b1;
               sclk  <= 1'b0;
               cs_n  <= '1;
            end
         endcase
      end
   end

endmodule
